// File: rtl/timer_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// timer_scheduler_pkg
// Shared definitions for the timer scheduler:
//   - per-channel register offsets (addr[1:0])
//   - control/status bit positions
//   - countdown step helper used by every channel
// -----------------------------------------------------------------------------
package timer_scheduler_pkg;

    // Register offsets within a channel (addr[1:0])
    localparam logic [1:0] REG_CNT_LO = 2'd0;  // W: reload[7:0]  R: count[7:0]
    localparam logic [1:0] REG_CNT_HI = 2'd1;  // W: reload[15:8] R: count[15:8]
    localparam logic [1:0] REG_CTRL   = 2'd2;  // R/W: control bits
    localparam logic [1:0] REG_STAT   = 2'd3;  // R: pending  W: 1 clears pending

    // Control register bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_PER_BIT  = 1;
    localparam int CTRL_IRQ_BIT  = 2;
    localparam int CTRL_WIDTH    = 3;

    // Status register bit positions
    localparam int STAT_PEND_BIT = 0;

    // Count value after one tick: decrement, or on expiry either reload
    // (periodic) or park at zero (one-shot).
    function automatic logic [15:0] count_step(
        input logic [15:0] count,
        input logic [15:0] reload,
        input logic        periodic
    );
        logic [15:0] nxt;
        if (count != 16'h0000) begin
            nxt = count - 16'h0001;
        end else if (periodic) begin
            nxt = reload;
        end else begin
            nxt = 16'h0000;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Shared prescaler: counts 0..INTERVAL and emits a one-cycle registered tick
// each time it wraps, i.e. one tick every INTERVAL+1 clk cycles.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - synchronous active-low reset
//   tick     - one-cycle pulse per prescaler period (registered)
// -----------------------------------------------------------------------------
module timer_prescaler #(
    parameter int                       DIVIDER_WIDTH = 15,
    parameter logic [DIVIDER_WIDTH-1:0] INTERVAL      = 15'd24000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [DIVIDER_WIDTH-1:0] div_r;
    logic                     tick_r;

    // Divider counter; wraps at INTERVAL and flags the wrap as a tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_r  <= {DIVIDER_WIDTH{1'b0}};
            tick_r <= 1'b0;
        end else if (div_r == INTERVAL) begin
            div_r  <= {DIVIDER_WIDTH{1'b0}};
            tick_r <= 1'b1;
        end else begin
            div_r  <= div_r + {{(DIVIDER_WIDTH-1){1'b0}}, 1'b1};
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
// Up to four independent 16-bit countdown timers sharing one prescaler,
// accessed through a small byte-wide register file.
//
// Parameters:
//   CHANNELS      - number of timer channels (1..4)
//   DIVIDER_WIDTH - width of the shared prescaler counter
//   INTERVAL      - prescaler terminal value (tick every INTERVAL+1 clocks)
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - synchronous active-low reset
//   addr     - [3:2] channel, [1:0] register
//   data_in  - CPU write data
//   wr       - write strobe, one access per high cycle
//   rd       - read strobe
//   data_out - registered read data, holds between reads
//   irq      - OR over channels of (pending AND irq_en)
//
// Build option:
//   TIMER_SCHEDULER_LATCH_EN - reading count[7:0] snapshots count[15:8] into
//   a per-channel latch that count[15:8] reads then return, giving a coherent
//   16-bit read. Without it count[15:8] reads the live value.
// -----------------------------------------------------------------------------
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int                       CHANNELS      = 4,
    parameter int                       DIVIDER_WIDTH = 15,
    parameter logic [DIVIDER_WIDTH-1:0] INTERVAL      = 15'd24000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] addr,
    input  logic [7:0] data_in,
    input  logic       wr,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       irq
);

    logic                tick_s;
    logic [1:0]          acc_chan_s;
    logic [1:0]          acc_reg_s;
    logic [7:0]          rd_a_s [CHANNELS];
    logic [CHANNELS-1:0] irq_vec_s;
    logic [7:0]          rdata_s;
    logic [7:0]          data_out_r;

    timer_prescaler #(
        .DIVIDER_WIDTH (DIVIDER_WIDTH),
        .INTERVAL      (INTERVAL)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s)
    );

    assign acc_chan_s = addr[3:2];
    assign acc_reg_s  = addr[1:0];

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic                  sel_s;
        logic                  wr_lo_s;
        logic                  wr_hi_s;
        logic                  wr_ctrl_s;
        logic                  wr_stat_s;
        logic                  load_s;
        logic                  run_s;
        logic                  expire_s;
        logic [15:0]           reload_r;
        logic [15:0]           count_r;
        logic [CTRL_WIDTH-1:0] ctrl_r;
        logic                  pending_r;
        logic [7:0]            cnt_hi_view_s;
        logic [7:0]            rdata_ch_s;

        // Access decode and tick/load arbitration; a load (enable 0->1)
        // suppresses the tick in the same cycle.
        always_comb begin
            sel_s     = (acc_chan_s == 2'(ch));
            wr_lo_s   = wr && sel_s && (acc_reg_s == REG_CNT_LO);
            wr_hi_s   = wr && sel_s && (acc_reg_s == REG_CNT_HI);
            wr_ctrl_s = wr && sel_s && (acc_reg_s == REG_CTRL);
            wr_stat_s = wr && sel_s && (acc_reg_s == REG_STAT);
            load_s    = wr_ctrl_s && data_in[CTRL_EN_BIT] && !ctrl_r[CTRL_EN_BIT];
            run_s     = tick_s && ctrl_r[CTRL_EN_BIT] && !load_s;
            expire_s  = run_s && (count_r == 16'h0000);
        end

        // Reload value; only consulted at the next load or periodic reload.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                reload_r <= 16'h0000;
            end else if (wr_lo_s) begin
                reload_r[7:0] <= data_in;
            end else if (wr_hi_s) begin
                reload_r[15:8] <= data_in;
            end else begin
                reload_r <= reload_r;
            end
        end

        // Countdown register.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                count_r <= 16'h0000;
            end else if (load_s) begin
                count_r <= reload_r;
            end else if (run_s) begin
                count_r <= count_step(count_r, reload_r, ctrl_r[CTRL_PER_BIT]);
            end else begin
                count_r <= count_r;
            end
        end

        // Control register; a one-shot expiry drops enable unless the CPU
        // writes control in that same cycle.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                ctrl_r <= {CTRL_WIDTH{1'b0}};
            end else if (wr_ctrl_s) begin
                ctrl_r <= data_in[CTRL_WIDTH-1:0];
            end else if (expire_s && !ctrl_r[CTRL_PER_BIT]) begin
                ctrl_r[CTRL_EN_BIT] <= 1'b0;
            end else begin
                ctrl_r <= ctrl_r;
            end
        end

        // Pending flag; expiry beats a simultaneous clear so no event is lost.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                pending_r <= 1'b0;
            end else if (expire_s) begin
                pending_r <= 1'b1;
            end else if (wr_stat_s && data_in[STAT_PEND_BIT]) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end

`ifdef TIMER_SCHEDULER_LATCH_EN
        logic [7:0] latch_r;

        // High-byte snapshot taken when the low byte is read.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                latch_r <= 8'h00;
            end else if (rd && sel_s && (acc_reg_s == REG_CNT_LO)) begin
                latch_r <= count_r[15:8];
            end else begin
                latch_r <= latch_r;
            end
        end

        assign cnt_hi_view_s = latch_r;
`else
        assign cnt_hi_view_s = count_r[15:8];
`endif

        // Per-channel read data selected by register offset.
        always_comb begin
            case (acc_reg_s)
                REG_CNT_LO: rdata_ch_s = count_r[7:0];
                REG_CNT_HI: rdata_ch_s = cnt_hi_view_s;
                REG_CTRL:   rdata_ch_s = {{(8-CTRL_WIDTH){1'b0}}, ctrl_r};
                REG_STAT:   rdata_ch_s = {7'b0000000, pending_r};
                default:    rdata_ch_s = 8'h00;
            endcase
        end

        assign rd_a_s[ch]    = rdata_ch_s;
        assign irq_vec_s[ch] = pending_r & ctrl_r[CTRL_IRQ_BIT];
    end

    // Channel read mux; channel numbers beyond CHANNELS match nothing and read 0.
    always_comb begin
        rdata_s = 8'h00;
        for (int i = 0; i < CHANNELS; i++) begin
            rdata_s = rdata_s | ((acc_chan_s == 2'(i)) ? rd_a_s[i] : 8'h00);
        end
    end

    // Read data register; updates only on a read strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_r <= 8'h00;
        end else if (rd) begin
            data_out_r <= rdata_s;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    assign data_out = data_out_r;
    assign irq      = |irq_vec_s;

endmodule

// File: tb/tb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_scheduler
// Directed bench for timer_scheduler with CHANNELS=2, INTERVAL=3 (tick every
// 4 clocks). A behavioural model of the register file and timers is stepped on
// every rising edge; data_out and irq are compared against it on every falling
// edge, and literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_timer_scheduler;

    localparam int          CH = 2;
    localparam int          DW = 15;
    localparam logic [14:0] IV = 15'd3;
    localparam int          P  = 4;     // clocks per tick

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] addr    = 4'h0;
    logic [7:0] data_in = 8'h00;
    logic       wr      = 1'b0;
    logic       rd      = 1'b0;
    logic [7:0] data_out;
    logic       irq;

    timer_scheduler #(
        .CHANNELS      (CH),
        .DIVIDER_WIDTH (DW),
        .INTERVAL      (IV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Four slots so that any addressed channel indexes safely.
    int          m_edges = 0;   // rising edges since the last reset edge
    int          m_ticks = 0;   // ticks seen by the channels so far
    bit          m_live  = 1'b0;
    logic [15:0] m_reload [4];
    logic [15:0] m_count  [4];
    bit          m_en [4];
    bit          m_per[4];
    bit          m_ie [4];
    bit          m_pend[4];
    logic [7:0]  m_latch[4];
    logic [7:0]  m_dout;

    function automatic bit m_irq();
        bit r = 1'b0;
        for (int k = 0; k < CH; k++) r = r | (m_pend[k] & m_ie[k]);
        return r;
    endfunction

    // True at a falling edge when the coming rising edge is a tick edge.
    function automatic bit tick_next();
        return (m_edges >= P) && ((m_edges % P) == 0);
    endfunction

    int mc, mr;
    bit mtk, mload, mrun, mfire, mwsel;

    // The prescaler wraps P edges after reset; its registered tick is acted
    // on by the channels at the following edge, then every P edges.
    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            m_edges = 0;
            m_live  = 1'b1;
            m_dout  = 8'h00;
            for (int k = 0; k < 4; k++) begin
                m_reload[k] = 16'h0000; m_count[k] = 16'h0000; m_latch[k] = 8'h00;
                m_en[k] = 1'b0; m_per[k] = 1'b0; m_ie[k] = 1'b0; m_pend[k] = 1'b0;
            end
        end else begin
            m_edges++;
            mtk = (m_edges > P) && (((m_edges - 1) % P) == 0);
            if (mtk) m_ticks++;
            mc = int'(addr[3:2]);
            mr = int'(addr[1:0]);
            if (rd) begin
                if (mc >= CH) m_dout = 8'h00;
                else if (mr == 0) m_dout = m_count[mc][7:0];
`ifdef TIMER_SCHEDULER_LATCH_EN
                else if (mr == 1) m_dout = m_latch[mc];
`else
                else if (mr == 1) m_dout = m_count[mc][15:8];
`endif
                else if (mr == 2) m_dout = {5'b00000, m_ie[mc], m_per[mc], m_en[mc]};
                else m_dout = {7'b0000000, m_pend[mc]};
                if (mc < CH && mr == 0) m_latch[mc] = m_count[mc][15:8];
            end
            for (int k = 0; k < CH; k++) begin
                mwsel = wr && (mc == k);
                mload = mwsel && (mr == 2) && data_in[0] && !m_en[k];
                mrun  = mtk && m_en[k] && !mload;
                mfire = mrun && (m_count[k] == 16'h0000);
                if (mfire) m_pend[k] = 1'b1;
                else if (mwsel && mr == 3 && data_in[0]) m_pend[k] = 1'b0;
                if (mload) m_count[k] = m_reload[k];
                else if (mrun) begin
                    if (m_count[k] != 16'h0000) m_count[k] = m_count[k] - 16'h0001;
                    else if (m_per[k]) m_count[k] = m_reload[k];
                end
                if (mwsel && mr == 2) begin
                    m_en[k] = data_in[0]; m_per[k] = data_in[1]; m_ie[k] = data_in[2];
                end else if (mfire && !m_per[k]) begin
                    m_en[k] = 1'b0;
                end
                if (mwsel && mr == 0) m_reload[k][7:0]  = data_in;
                if (mwsel && mr == 1) m_reload[k][15:8] = data_in;
            end
        end
    end

    // Every-cycle comparison of the outputs against the model.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("data_out", 32'(data_out), 32'(m_dout));
            check("irq", 32'(irq), 32'(m_irq()));
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; data_in = d; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk); addr = a; rd = 1'b1;
        @(negedge clk); rd = 1'b0; d = data_out;
    endtask

    task automatic wait_tick_next();
        int g = 0;
        do begin
            @(negedge clk); g++;
        end while (!tick_next() && g < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int mark;
        int guard;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        // Periodic reload 2: pending on 3rd tick, then every 3 ticks
        bus_wr(4'h0, 8'h02); bus_wr(4'h1, 8'h00); bus_wr(4'h2, 8'h03);
        mark = m_ticks;
        guard = 0; d = 8'h00;
        while (!d[0] && guard < 30) begin bus_rd(4'h3, d); guard++; end
        check("per_pend_seen1", 32'(d[0]), 32'h1);
        check("per_ticks1", 32'(m_ticks - mark), 32'd3);
        bus_rd(4'h0, d);
        check("per_reload_cnt", 32'(d), 32'h02);
        bus_wr(4'h3, 8'h01);
        guard = 0; d = 8'h00;
        while (!d[0] && guard < 30) begin bus_rd(4'h3, d); guard++; end
        check("per_pend_seen2", 32'(d[0]), 32'h1);
        check("per_ticks2", 32'(m_ticks - mark), 32'd6);
        bus_wr(4'h2, 8'h00);

        // One-shot with irq_en on channel 1
        bus_wr(4'h4, 8'h01); bus_wr(4'h5, 8'h00); bus_wr(4'h6, 8'h05);
        mark = m_ticks;
        guard = 0;
        while (!irq && guard < 40) begin @(negedge clk); guard++; end
        check("os_irq_rise", 32'(irq), 32'h1);
        check("os_ticks", 32'(m_ticks - mark), 32'd2);
        bus_rd(4'h6, d); check("os_ctrl", 32'(d), 32'h04);
        repeat (12) @(negedge clk);
        bus_rd(4'h4, d); check("os_cnt_lo", 32'(d), 32'h00);
        bus_rd(4'h5, d); check("os_cnt_hi", 32'(d), 32'h00);
        check("os_irq_held", 32'(irq), 32'h1);
        bus_wr(4'h7, 8'h01);
        check("os_irq_clear", 32'(irq), 32'h0);

        // Reload 0 periodic: pending every tick, clear vs set collision
        bus_wr(4'h0, 8'h00); bus_wr(4'h1, 8'h00); bus_wr(4'h2, 8'h03);
        wait_tick_next();
        addr = 4'h3; data_in = 8'h01; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        bus_rd(4'h3, d); check("z_set_wins", 32'(d), 32'h01);
        wait_tick_next();
        @(negedge clk);
        addr = 4'h3; data_in = 8'h01; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        bus_rd(4'h3, d); check("z_clear_between", 32'(d), 32'h00);
        bus_wr(4'h2, 8'h00); bus_wr(4'h3, 8'h01);

        // Coherent 16-bit read; enable coincides with a tick (load wins)
        bus_wr(4'h4, 8'h00); bus_wr(4'h5, 8'h01);
        wait_tick_next();
        addr = 4'h6; data_in = 8'h01; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        bus_rd(4'h4, d); check("lat_lo_loaded", 32'(d), 32'h00);
        repeat (2) @(negedge clk);
        bus_rd(4'h5, d);
`ifdef TIMER_SCHEDULER_LATCH_EN
        check("lat_hi", 32'(d), 32'h01);
`else
        check("lat_hi", 32'(d), 32'h00);
`endif
        bus_rd(4'h4, d); check("lat_lo_after", 32'(d), 32'hFF);
        bus_wr(4'h6, 8'h00);

        // Out-of-range channels
        bus_wr(4'hC, 8'hAA); bus_wr(4'hE, 8'h07); bus_wr(4'h8, 8'h55);
        bus_rd(4'h4, d);
        bus_rd(4'hE, d); check("oor_ctrl", 32'(d), 32'h00);
        bus_rd(4'hC, d); check("oor_lo", 32'(d), 32'h00);
        bus_rd(4'hB, d); check("oor_stat", 32'(d), 32'h00);
        bus_rd(4'h6, d); check("oor_ch1_ctrl", 32'(d), 32'h00);

        // Reset mid-countdown
        bus_wr(4'h0, 8'h05); bus_wr(4'h1, 8'h00); bus_wr(4'h2, 8'h07);
        repeat (10) @(negedge clk);
        bus_rd(4'h2, d); check("mr_ctrl_before", 32'(d), 32'h07);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check("mr_data_out", 32'(data_out), 32'h00);
        check("mr_irq", 32'(irq), 32'h0);
        bus_rd(4'h0, d); check("mr_cnt", 32'(d), 32'h00);
        bus_rd(4'h2, d); check("mr_ctrl", 32'(d), 32'h00);
        repeat (40) @(negedge clk);
        check("mr_irq_late", 32'(irq), 32'h0);
        bus_rd(4'h3, d); check("mr_pend_late", 32'(d), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent timer channels (1..4).
REQ-002 SHALL have parameter DIVIDER_WIDTH, default 15, width of the shared prescaler counter.
REQ-003 SHALL have parameter INTERVAL, default 15'd24000, prescaler terminal value; one tick every INTERVAL+1 clk cycles.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port addr  input  4  register address: [3:2] channel, [1:0] register.
REQ-007 SHALL have port data_in  input  8  CPU write data.
REQ-008 SHALL have port wr  input  1  write strobe, one access per high cycle.
REQ-009 SHALL have port rd  input  1  read strobe.
REQ-010 SHALL have port data_out  output  8  registered read data.
REQ-011 SHALL have port irq  output  1  OR of (pending AND irq_en) over all channels.

Function
REQ-012 SHALL use one shared prescaler: counts 0..INTERVAL, at INTERVAL returns to 0 and asserts a 1-cycle tick.
REQ-013 Per-channel registers: reg0 reload[7:0] (W) / count[7:0] (R); reg1 reload[15:8] (W) / count[15:8] (R); reg2 control (bit0 enable, bit1 periodic, bit2 irq_en; R/W); reg3 status (R bit0 pending; W 1 to bit0 clears pending).
REQ-014 Writing control with enable 0->1 SHALL load count from reload; new count visible on the following cycle.
REQ-015 On tick with enable=1: count!=0 -> count-1; count==0 -> set pending, then periodic=1 reloads count, periodic=0 clears enable and holds count at 0.
REQ-016 Reload=0 in periodic mode SHALL set pending on every tick.
REQ-017 Writes to reload while enabled SHALL NOT change count until the next reload event.
REQ-018 Pending clear (write) and expiry in the same cycle: set wins, pending stays 1.
REQ-019 Enable 0->1 write coinciding with tick: load wins, no decrement that cycle.
REQ-020 Channel addresses >= CHANNELS: writes ignored, reads return 8'h00.
REQ-021 data_out SHALL update one cycle after rd high and hold its value otherwise.
REQ-022 irq SHALL be combinational from registered pending/irq_en, no added latency.

Reset
REQ-023 While reset_n=0 at clk edge: prescaler=0, all count/reload/control/pending=0, data_out=8'h00, irq=0.
REQ-024 Reset mid-countdown SHALL abort the channel; no pending set by the aborted count.

Configuration
REQ-025 With TIMER_SCHEDULER_LATCH_EN defined, reading reg0 SHALL snapshot count[15:8] into a per-channel latch and reg1 reads return the latch (coherent 16-bit read); without it, reg1 returns live count[15:8].
REQ-026 The latch SHALL reset to 0 and shall be absent from the netlist when the macro is undefined.

Structure
REQ-027 Package timer_scheduler_pkg SHALL hold register offsets (REG_CNT_LO, REG_CNT_HI, REG_CTRL, REG_STAT) and control bit indices.
REQ-028 Prescaler SHALL be sub-module timer_prescaler (clk, reset_n, tick); channel logic generated per channel in the top.

Verification (INTERVAL=3, tick every 4 clk)
REQ-029 Reload=16'h0002, ctrl=3'b011 -> pending set on 3rd tick after enable and every 3 ticks thereafter; count reloads to 2.
REQ-030 Reload=16'h0001, ctrl=3'b101 (one-shot, irq_en) -> irq high after 2nd tick, enable reads 0, count holds 0; write 8'h01 to reg3 -> irq low next cycle.
REQ-031 Reload=0, periodic -> pending on every tick; clear written in tick cycle -> pending remains 1.
REQ-032 Count=16'h0100, read reg0 then decrement to 16'h00FF, read reg1 -> 8'h01 with LATCH_EN, 8'h00 without.
REQ-033 reset_n low for 1 cycle mid-countdown -> all registers 0, irq 0, no later pending.
REQ-034 Write/read channel 3 with CHANNELS=2 -> no state change, data_out=8'h00.
